axi_w_data_router: RTL and testbench

Write-data router for one master port of the AXI node. Holds a FIFO of target-port IDs pushed by the write-address allocator, one per accepted AW arbitration, and steers W beats from the recorded target port to the master port in AW grant order. Each burst is forwarded until `wlast`, then the FIFO is popped. It also back-pressures the address allocator through `grant_FIFO_ID_o` when the FIFO is full.

---
 rtl/axi_node_pkg.sv | 22 ++
 rtl/axi_id_fifo.sv | 70 +++++++
 rtl/axi_w_data_router.sv | 78 +++++++
 tb/tb_axi_w_data_router.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_node_pkg.sv
// Shared types for the AXI node: the target-port ID entry pushed by the AW allocator
// and consumed by the W data router.
package axi_node_pkg;

    localparam int N_TARG_PORT_DEF = 7;
    localparam int LOG_N_TARG_DEF  = $clog2(N_TARG_PORT_DEF);
    localparam int ID_W            = LOG_N_TARG_DEF + N_TARG_PORT_DEF;

    typedef struct packed {
        logic [LOG_N_TARG_DEF-1:0]  idx;
        logic [N_TARG_PORT_DEF-1:0] oneHot;
    } id_entry_t;

    // Builds a consistent binary + one-hot ID for a target port index.
    function automatic id_entry_t makeId(input logic [LOG_N_TARG_DEF-1:0] idx);
        id_entry_t e;
        e.idx    = idx;
        e.oneHot = N_TARG_PORT_DEF'(1) << idx;
        return e;
    endfunction

endpackage

// File: rtl/axi_id_fifo.sv
// Generic synchronous FIFO with occupancy counter; head data is read combinationally
// from the entry at the read pointer.
module axi_id_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i & ~full_o;
    assign doPop   = pop_i & ~empty_o;
    assign data_o  = mem_q[rdPtr_q];

    // Full and empty share pointer values, so occupancy is tracked separately.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (doPush && !doPop) begin
            count_d = count_q + CNT_W'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/axi_w_data_router.sv
// W-channel router for one master port: forwards write bursts from target ports
// in the order their AW requests were granted, one burst per queued ID.
module axi_w_data_router
    import axi_node_pkg::*;
#(
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_USER_W  = 6,
    parameter int N_TARG_PORT = N_TARG_PORT_DEF,
    parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [N_TARG_PORT-1:0][AXI_DATA_W-1:0]    wdata_i,
    input  logic [N_TARG_PORT-1:0][AXI_DATA_W/8-1:0]  wstrb_i,
    input  logic [N_TARG_PORT-1:0]                    wlast_i,
    input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]    wuser_i,
    input  logic [N_TARG_PORT-1:0]                    wvalid_i,
    output logic [N_TARG_PORT-1:0]                    wready_o,
    output logic [AXI_DATA_W-1:0]                     wdata_o,
    output logic [AXI_DATA_W/8-1:0]                   wstrb_o,
    output logic                                      wlast_o,
    output logic [AXI_USER_W-1:0]                     wuser_o,
    output logic                                      wvalid_o,
    input  logic                                      wready_i,
    input  logic                                      push_ID_i,
    input  logic [LOG_N_TARG+N_TARG_PORT-1:0]         ID_i,
    output logic                                      grant_FIFO_ID_o
);

    localparam int IDW = LOG_N_TARG + N_TARG_PORT;

    logic                   fifoFull;
    logic                   fifoEmpty;
    logic                   popId;
    logic [IDW-1:0]         headId;
    logic [N_TARG_PORT-1:0] headOneHot;
    logic [LOG_N_TARG-1:0]  headIdx;

    axi_id_fifo #(
        .WIDTH (IDW),
        .DEPTH (FIFO_DEPTH)
    ) u_idFifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_ID_i & grant_FIFO_ID_o),
        .pop_i   (popId),
        .data_i  (ID_i),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .data_o  (headId)
    );

    assign grant_FIFO_ID_o = ~fifoFull;
    assign headOneHot      = headId[N_TARG_PORT-1:0];
    assign headIdx         = headId[IDW-1:N_TARG_PORT];

    // The one-hot half gates handshakes; the binary half steers the payload mux.
    assign wvalid_o = ~fifoEmpty & |(wvalid_i & headOneHot);
    assign wready_o = fifoEmpty ? '0 : (headOneHot & {N_TARG_PORT{wready_i}});
    assign popId    = wvalid_o & wready_i & wlast_o;

    always_comb begin
        wdata_o = '0;
        wstrb_o = '0;
        wlast_o = 1'b0;
        wuser_o = '0;
        for (int i = 0; i < N_TARG_PORT; i++) begin
            if (headIdx == LOG_N_TARG'(i)) begin
                wdata_o = wdata_i[i];
                wstrb_o = wstrb_i[i];
                wlast_o = wlast_i[i];
                wuser_o = wuser_i[i];
            end
        end
    end

endmodule

// File: tb/tb_axi_w_data_router.sv
// Self-checking bench for axi_w_data_router: a queue of granted port IDs plus per-port
// burst queues predict the handshakes, the forwarded payload and the beat order.
module tb_axi_w_data_router;
    import axi_node_pkg::*;

    localparam int N     = N_TARG_PORT_DEF;
    localparam int LOGN  = LOG_N_TARG_DEF;
    localparam int DW    = 64;
    localparam int SW    = DW / 8;
    localparam int UW    = 6;
    localparam int DEPTH = 8;
    localparam int IDW   = ID_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N-1:0][DW-1:0]     wdata_i;
    logic [N-1:0][SW-1:0]     wstrb_i;
    logic [N-1:0]             wlast_i;
    logic [N-1:0][UW-1:0]     wuser_i;
    logic [N-1:0]             wvalid_i;
    logic [N-1:0]             wready_o;
    logic [DW-1:0]            wdata_o;
    logic [SW-1:0]            wstrb_o;
    logic                     wlast_o;
    logic [UW-1:0]            wuser_o;
    logic                     wvalid_o;
    logic                     wready_i;
    logic                     push_ID_i;
    logic [IDW-1:0]           ID_i;
    logic                     grant_FIFO_ID_o;

    always #5 clk = ~clk;

    axi_w_data_router #(
        .AXI_DATA_W  (DW),
        .AXI_USER_W  (UW),
        .N_TARG_PORT (N),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wdata_i         (wdata_i),
        .wstrb_i         (wstrb_i),
        .wlast_i         (wlast_i),
        .wuser_i         (wuser_i),
        .wvalid_i        (wvalid_i),
        .wready_o        (wready_o),
        .wdata_o         (wdata_o),
        .wstrb_o         (wstrb_o),
        .wlast_o         (wlast_o),
        .wuser_o         (wuser_o),
        .wvalid_o        (wvalid_o),
        .wready_i        (wready_i),
        .push_ID_i       (push_ID_i),
        .ID_i            (ID_i),
        .grant_FIFO_ID_o (grant_FIFO_ID_o)
    );

    int checks = 0;
    int passes = 0;

    // Reference state: granted port order, and per-port pending beats/burst lengths.
    int            modelQ[$];
    logic [DW-1:0] pendData [N][$];
    int            pendLen  [N][$];
    int            beatCnt  [N];
    logic [DW:0]   expStream[$];
    logic [DW:0]   actStream[$];
    bit            srcEnable;
    bit            allValid;
    int            pushPort;
    int            pushLen;
    logic [N-1:0]  hsPorts;

    logic [N+1:0]        expCtrl;
    logic                expPayValid;
    logic [SW+UW+DW:0]   expPay;

    function automatic logic [SW-1:0] strbOf(input logic [DW-1:0] d);
        return d[SW-1:0] ^ d[DW-1:DW-SW];
    endfunction

    function automatic logic [UW-1:0] userOf(input logic [DW-1:0] d);
        return d[UW+7:8];
    endfunction

    task automatic driveSources();
        for (int p = 0; p < N; p++) begin
            if (srcEnable && pendLen[p].size() != 0) begin
                wvalid_i[p] = 1'b1;
                wdata_i[p]  = pendData[p][0];
                wstrb_i[p]  = strbOf(pendData[p][0]);
                wuser_i[p]  = userOf(pendData[p][0]);
                wlast_i[p]  = (beatCnt[p] == pendLen[p][0] - 1);
            end else begin
                wvalid_i[p] = allValid;
                wdata_i[p]  = {$urandom, $urandom};
                wstrb_i[p]  = SW'($urandom);
                wuser_i[p]  = UW'($urandom);
                wlast_i[p]  = 1'($urandom);
            end
        end
    endtask

    task automatic computeExp();
        int hp;
        logic [N-1:0] rdy;
        logic valid;
        rdy         = '0;
        valid       = 1'b0;
        expPayValid = 1'b0;
        expPay      = '0;
        if (modelQ.size() != 0) begin
            hp    = modelQ[0];
            valid = wvalid_i[hp];
            if (wready_i) rdy[hp] = 1'b1;
            if (valid && srcEnable && pendLen[hp].size() != 0) begin
                expPayValid = 1'b1;
                expPay = {strbOf(pendData[hp][0]), 1'(beatCnt[hp] == pendLen[hp][0] - 1),
                          userOf(pendData[hp][0]), pendData[hp][0]};
            end
        end
        expCtrl = {1'(modelQ.size() != DEPTH), valid, rdy};
    endtask

    task automatic setPush(input int port, input int len);
        push_ID_i = 1'b1;
        ID_i      = makeId(LOGN'(port));
        pushPort  = port;
        pushLen   = len;
    endtask

    // One clock: capture handshakes, advance the model at the edge, then drive new beats.
    task automatic tick();
        bit doPop;
        bit doPush;
        logic [DW-1:0] d;
        hsPorts = wready_o & wvalid_i;
        if (wvalid_o === 1'b1 && wready_i) actStream.push_back({wlast_o, wdata_o});
        @(posedge clk);
        if (rst) begin
            modelQ.delete();
            expStream.delete();
            actStream.delete();
            for (int p = 0; p < N; p++) begin
                pendData[p].delete();
                pendLen[p].delete();
                beatCnt[p] = 0;
            end
        end else begin
            doPop  = modelQ.size() != 0 && wvalid_i[modelQ[0]] && wready_i && wlast_i[modelQ[0]];
            doPush = push_ID_i && modelQ.size() != DEPTH;
            if (doPop) void'(modelQ.pop_front());
            if (doPush) begin
                modelQ.push_back(pushPort);
                pendLen[pushPort].push_back(pushLen);
                for (int b = 0; b < pushLen; b++) begin
                    d = {$urandom, $urandom};
                    pendData[pushPort].push_back(d);
                    expStream.push_back({1'(b == pushLen - 1), d});
                end
            end
            for (int p = 0; p < N; p++) begin
                if (hsPorts[p] === 1'b1 && pendLen[p].size() != 0) begin
                    void'(pendData[p].pop_front());
                    if (beatCnt[p] == pendLen[p][0] - 1) begin
                        void'(pendLen[p].pop_front());
                        beatCnt[p] = 0;
                    end else begin
                        beatCnt[p]++;
                    end
                end
            end
        end
        #2;
        driveSources();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; allValid = 1'b1; srcEnable = 1'b0; wready_i = 1'b1; push_ID_i = 1'b0;
        driveSources();
        tick();
        tick();
        checks++;
        if ({grant_FIFO_ID_o, wvalid_o, wready_o} !== {1'b1, 1'b0, {N{1'b0}}})
            $display("[TB] FAIL reset_ctrl: got %b expected %b", {grant_FIFO_ID_o, wvalid_o, wready_o}, {1'b1, 1'b0, {N{1'b0}}});
        else passes++;
        rst = 1'b0;
        #1;
        computeExp();
        checks++;
        if ({grant_FIFO_ID_o, wvalid_o, wready_o} !== expCtrl)
            $display("[TB] FAIL reset_release: got %b expected %b", {grant_FIFO_ID_o, wvalid_o, wready_o}, expCtrl);
        else passes++;
        allValid = 1'b0;
        tick();
    endtask

    task automatic test_single_burst();
        srcEnable = 1'b1; allValid = 1'b1; wready_i = 1'b1;
        setPush(3, 4);
        driveSources();
        #1;
        computeExp();
        checks++;
        if ({grant_FIFO_ID_o, wvalid_o, wready_o} !== expCtrl)
            $display("[TB] FAIL single_no_bypass: got %b expected %b", {grant_FIFO_ID_o, wvalid_o, wready_o}, expCtrl);
        else passes++;
        tick();
        push_ID_i = 1'b0; allValid = 1'b0;
        driveSources();
        #1;
        for (int c = 0; c < 12 && modelQ.size() != 0; c++) begin
            computeExp();
            checks++;
            if ({grant_FIFO_ID_o, wvalid_o, wready_o} !== expCtrl)
                $display("[TB] FAIL single_ctrl: got %b expected %b", {grant_FIFO_ID_o, wvalid_o, wready_o}, expCtrl);
            else passes++;
            if (expPayValid) begin
                checks++;
                if ({wstrb_o, wlast_o, wuser_o, wdata_o} !== expPay)
                    $display("[TB] FAIL single_payload: got %h expected %h", {wstrb_o, wlast_o, wuser_o, wdata_o}, expPay);
                else passes++;
            end
            tick();
        end
        checks++;
        if (actStream.size() != expStream.size() || expStream.size() != 4)
            $display("[TB] FAIL single_beat_count: got %0d expected 4", actStream.size());
        else passes++;
        for (int i = 0; i < expStream.size() && i < actStream.size(); i++) begin
            checks++;
            if (actStream[i] !== expStream[i])
                $display("[TB] FAIL single_beat_%0d: got %h expected %h", i, actStream[i], expStream[i]);
            else passes++;
        end
        actStream.delete(); expStream.delete();
        allValid = 1'b1;
        driveSources();
        #1;
        computeExp();
        checks++;
        if ({grant_FIFO_ID_o, wvalid_o, wready_o} !== expCtrl)
            $display("[TB] FAIL single_after_empty: got %b expected %b", {grant_FIFO_ID_o, wvalid_o, wready_o}, expCtrl);
        else passes++;
        allValid = 1'b0;
        tick();
    endtask

    task automatic test_ordering();
        srcEnable = 1'b0; wready_i = 1'b1;
        setPush(5, 2);
        tick();
        setPush(1, 2);
        tick();
        push_ID_i = 1'b0; srcEnable = 1'b1;
        driveSources();
        #1;
        for (int c = 0; c < 12 && modelQ.size() != 0; c++) begin
            computeExp();
            checks++;
            if ({grant_FIFO_ID_o, wvalid_o, wready_o} !== expCtrl)
                $display("[TB] FAIL order_ctrl: got %b expected %b", {grant_FIFO_ID_o, wvalid_o, wready_o}, expCtrl);
            else passes++;
            if (expPayValid) begin
                checks++;
                if ({wstrb_o, wlast_o, wuser_o, wdata_o} !== expPay)
                    $display("[TB] FAIL order_payload: got %h expected %h", {wstrb_o, wlast_o, wuser_o, wdata_o}, expPay);
                else passes++;
            end
            tick();
        end
        checks++;
        if (actStream.size() != expStream.size())
            $display("[TB] FAIL order_beat_count: got %0d expected %0d", actStream.size(), expStream.size());
        else passes++;
        for (int i = 0; i < expStream.size() && i < actStream.size(); i++) begin
            checks++;
            if (actStream[i] !== expStream[i])
                $display("[TB] FAIL order_beat_%0d: got %h expected %h", i, actStream[i], expStream[i]);
            else passes++;
        end
        actStream.delete(); expStream.delete();
    endtask

    task automatic test_full();
        srcEnable = 1'b0; allValid = 1'b0; wready_i = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            setPush(int'($urandom_range(0, N - 1)), 1);
            driveSources();
            #1;
            computeExp();
            checks++;
            if ({grant_FIFO_ID_o, wvalid_o, wready_o} !== expCtrl)
                $display("[TB] FAIL full_fill_%0d: got %b expected %b", i, {grant_FIFO_ID_o, wvalid_o, wready_o}, expCtrl);
            else passes++;
            tick();
        end
        push_ID_i = 1'b0; srcEnable = 1'b1;
        driveSources();
        #1;
        for (int c = 0; c < 20 && modelQ.size() != 0; c++) begin
            computeExp();
            checks++;
            if ({grant_FIFO_ID_o, wvalid_o, wready_o} !== expCtrl)
                $display("[TB] FAIL full_drain_ctrl: got %b expected %b", {grant_FIFO_ID_o, wvalid_o, wready_o}, expCtrl);
            else passes++;
            tick();
        end
        checks++;
        if (actStream.size() != DEPTH || expStream.size() != DEPTH)
            $display("[TB] FAIL full_beat_count: got %0d expected %0d", actStream.size(), DEPTH);
        else passes++;
        actStream.delete(); expStream.delete();
        allValid = 1'b1; wready_i = 1'b0;
        driveSources();
        #1;
        computeExp();
        checks++;
        if ({grant_FIFO_ID_o, wvalid_o, wready_o} !== expCtrl)
            $display("[TB] FAIL full_dropped_push: got %b expected %b", {grant_FIFO_ID_o, wvalid_o, wready_o}, expCtrl);
        else passes++;
        allValid = 1'b0;
        tick();
    endtask

    task automatic test_push_pop();
        srcEnable = 1'b0; wready_i = 1'b1;
        setPush(2, 1); tick();
        setPush(4, 1); tick();
        setPush(6, 1); tick();
        srcEnable = 1'b1;
        setPush(0, 1);
        driveSources();
        #1;
        for (int c = 0; c < 12 && modelQ.size() != 0; c++) begin
            computeExp();
            checks++;
            if ({grant_FIFO_ID_o, wvalid_o, wready_o} !== expCtrl)
                $display("[TB] FAIL pushpop_ctrl: got %b expected %b", {grant_FIFO_ID_o, wvalid_o, wready_o}, expCtrl);
            else passes++;
            tick();
            push_ID_i = 1'b0;
        end
        checks++;
        if (actStream.size() != 4 || expStream.size() != 4)
            $display("[TB] FAIL pushpop_beat_count: got %0d expected 4", actStream.size());
        else passes++;
        for (int i = 0; i < expStream.size() && i < actStream.size(); i++) begin
            checks++;
            if (actStream[i] !== expStream[i])
                $display("[TB] FAIL pushpop_beat_%0d: got %h expected %h", i, actStream[i], expStream[i]);
            else passes++;
        end
        actStream.delete(); expStream.delete();
        allValid = 1'b1; wready_i = 1'b0;
        driveSources();
        #1;
        computeExp();
        checks++;
        if ({grant_FIFO_ID_o, wvalid_o, wready_o} !== expCtrl)
            $display("[TB] FAIL pushpop_empty: got %b expected %b", {grant_FIFO_ID_o, wvalid_o, wready_o}, expCtrl);
        else passes++;
        allValid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        srcEnable = 1'b1;
        setPush(int'($urandom_range(0, N - 1)), 8);
        tick();
        push_ID_i = 1'b0;
        for (int c = 0; c < 200 && modelQ.size() != 0; c++) begin
            wready_i = 1'($urandom);
            #1;
            computeExp();
            checks++;
            if ({grant_FIFO_ID_o, wvalid_o, wready_o} !== expCtrl)
                $display("[TB] FAIL bp_ctrl: got %b expected %b", {grant_FIFO_ID_o, wvalid_o, wready_o}, expCtrl);
            else passes++;
            if (expPayValid) begin
                checks++;
                if ({wstrb_o, wlast_o, wuser_o, wdata_o} !== expPay)
                    $display("[TB] FAIL bp_payload: got %h expected %h", {wstrb_o, wlast_o, wuser_o, wdata_o}, expPay);
                else passes++;
            end
            tick();
        end
        checks++;
        if (actStream.size() != 8 || expStream.size() != 8 || modelQ.size() != 0)
            $display("[TB] FAIL bp_beat_count: got %0d expected 8", actStream.size());
        else passes++;
        for (int i = 0; i < expStream.size() && i < actStream.size(); i++) begin
            checks++;
            if (actStream[i] !== expStream[i])
                $display("[TB] FAIL bp_beat_%0d: got %h expected %h", i, actStream[i], expStream[i]);
            else passes++;
        end
        actStream.delete(); expStream.delete();
    endtask

    task automatic test_mid_burst_reset();
        srcEnable = 1'b1; wready_i = 1'b1;
        setPush(int'($urandom_range(0, N - 1)), 8);
        tick();
        push_ID_i = 1'b0;
        setPush(int'($urandom_range(0, N - 1)), 2);
        tick();
        push_ID_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            computeExp();
            checks++;
            if ({grant_FIFO_ID_o, wvalid_o, wready_o} !== expCtrl)
                $display("[TB] FAIL rstmid_ctrl: got %b expected %b", {grant_FIFO_ID_o, wvalid_o, wready_o}, expCtrl);
            else passes++;
            tick();
        end
        rst = 1'b1; allValid = 1'b1;
        tick();
        #1;
        checks++;
        if ({grant_FIFO_ID_o, wvalid_o, wready_o} !== {1'b1, 1'b0, {N{1'b0}}})
            $display("[TB] FAIL rstmid_outputs: got %b expected %b", {grant_FIFO_ID_o, wvalid_o, wready_o}, {1'b1, 1'b0, {N{1'b0}}});
        else passes++;
        rst = 1'b0;
        tick();
        allValid = 1'b0;
        driveSources();
        #1;
    endtask

    task automatic test_random();
        srcEnable = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (c < 250 && $urandom_range(0, 2) == 0) setPush(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 4)));
            else push_ID_i = 1'b0;
            wready_i = ($urandom_range(0, 3) != 0);
            #1;
            computeExp();
            checks++;
            if ({grant_FIFO_ID_o, wvalid_o, wready_o} !== expCtrl)
                $display("[TB] FAIL rand_ctrl: got %b expected %b", {grant_FIFO_ID_o, wvalid_o, wready_o}, expCtrl);
            else passes++;
            if (expPayValid) begin
                checks++;
                if ({wstrb_o, wlast_o, wuser_o, wdata_o} !== expPay)
                    $display("[TB] FAIL rand_payload: got %h expected %h", {wstrb_o, wlast_o, wuser_o, wdata_o}, expPay);
                else passes++;
            end
            tick();
            if (c >= 250 && modelQ.size() == 0) break;
        end
        push_ID_i = 1'b0;
        checks++;
        if (actStream.size() != expStream.size() || modelQ.size() != 0)
            $display("[TB] FAIL rand_beat_count: got %0d expected %0d", actStream.size(), expStream.size());
        else passes++;
        for (int i = 0; i < expStream.size() && i < actStream.size(); i++) begin
            checks++;
            if (actStream[i] !== expStream[i])
                $display("[TB] FAIL rand_beat_%0d: got %h expected %h", i, actStream[i], expStream[i]);
            else passes++;
        end
        actStream.delete(); expStream.delete();
    endtask

    initial begin
        rst = 1'b1; push_ID_i = 1'b0; ID_i = '0; wready_i = 1'b0;
        srcEnable = 1'b0; allValid = 1'b0; pushPort = 0; pushLen = 1;
        for (int p = 0; p < N; p++) beatCnt[p] = 0;
        driveSources();
        test_reset();
        test_single_burst();
        test_ordering();
        test_full();
        test_push_pop();
        test_backpressure();
        test_mid_burst_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
